// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single common data bus (CDB) among the result producers
//   (index 0 = ALU, 1 = LSB, 2 = Branch). Each producer hands a {tag, data}
//   result over a valid/ready handshake into its own one-entry holding
//   buffer. Every cycle at most one buffered result wins and is driven onto
//   the registered CDB outputs, which feed every RS/ROB snoop port.
//   A mispredict flush (clear) discards everything pending.
//
// Configuration:
//   CDB_ARB_RR_EN  defined   -> round-robin arbitration starting at r_rr_ptr
//                  undefined -> fixed priority, lowest index wins
//                               (ALU > LSB > Branch); no pointer exists.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   rdy        in   global ready; 0 freezes all state
//   clear      in   synchronous flush, has priority over rdy
//   req_valid  in   [NUM_SRC]         per-source result valid
//   req_tag    in   [NUM_SRC*TAG_W]   per-source ROB tag, source i at [i*TAG_W +: TAG_W]
//   req_data   in   [NUM_SRC*DATA_W]  per-source result, source i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_SRC]         per-source accept (combinational)
//   cdb_valid  out  broadcast valid (one-cycle pulse per winner)
//   cdb_tag    out  [TAG_W]           broadcast ROB tag
//   cdb_data   out  [DATA_W]          broadcast data
//   cdb_src    out  [NUM_SRC]         one-hot source of the current broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_SRC-1:0]        cdb_src
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] r_buf_valid;
  logic [TAG_W-1:0]   r_buf_tag  [NUM_SRC];
  logic [DATA_W-1:0]  r_buf_data [NUM_SRC];

  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [NUM_SRC-1:0] r_cdb_src;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic               w_block;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_accept;
  logic               w_found;
  logic [TAG_W-1:0]   w_req_tag  [NUM_SRC];
  logic [DATA_W-1:0]  w_req_data [NUM_SRC];
  logic [TAG_W-1:0]   w_win_tag;
  logic [DATA_W-1:0]  w_win_data;

  // Nothing may be accepted while in reset, flushing or stalled; inputs
  // presented in such a cycle are simply not taken.
  assign w_block = rst | clear | ~rdy;

  // ---------------------------------------------------------------------------
  // Per-source input unpacking and ready generation
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_req_tag[gi]  = req_tag[gi*TAG_W +: TAG_W];
      assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
      // A granted buffer empties on this edge, so it can take a new entry
      // at the same time: a winning source sustains one result per cycle.
      assign req_ready[gi]  = ~w_block & (~r_buf_valid[gi] | w_grant[gi]);
    end
  endgenerate

  assign w_accept = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef CDB_ARB_RR_EN
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_rr_next;

  // Round-robin as two priority passes: first the indices at or above the
  // pointer, then the ones below it (the wrap-around part of the search).
  always_comb begin
    w_grant   = '0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && r_buf_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_grant[i] = 1'b1;
        w_win_idx  = PTR_W'(i);
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && r_buf_valid[i] && (i < int'(r_rr_ptr))) begin
        w_grant[i] = 1'b1;
        w_win_idx  = PTR_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_win_idx == PTR_W'(NUM_SRC - 1)) ? '0
                                                        : PTR_W'(w_win_idx + 1'b1);
`else
  // Fixed priority: lowest-indexed valid buffer wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && r_buf_valid[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

  // Winner mux: grant is one-hot, so an AND-OR reduction selects the entry.
  always_comb begin
    w_win_tag  = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_win_tag  = w_win_tag  | r_buf_tag[i];
        w_win_data = w_win_data | r_buf_data[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state: buffers, CDB output registers, round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // Both reset and flush drop any pending result so it is never broadcast.
      r_buf_valid <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
`ifdef CDB_ARB_RR_EN
      r_rr_ptr    <= '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // A new entry on the same edge as a grant replaces the old one.
        if (w_accept[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_tag[i]   <= w_req_tag[i];
          r_buf_data[i]  <= w_req_data[i];
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end

      if (w_found) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_win_tag;
        r_cdb_data  <= w_win_data;
        r_cdb_src   <= w_grant;
`ifdef CDB_ARB_RR_EN
        r_rr_ptr    <= w_rr_next;
`endif
      end else begin
        r_cdb_valid <= 1'b0;
        r_cdb_tag   <= '0;
        r_cdb_data  <= '0;
        r_cdb_src   <= '0;
      end
    end
    // rdy = 0: everything holds, including a CDB pulse in progress.
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NUM_SRC = 3;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rdy;
  logic                      clear;
  logic [NUM_SRC-1:0]        req_valid;
  logic [NUM_SRC*TAG_W-1:0]  req_tag;
  logic [NUM_SRC*DATA_W-1:0] req_data;
  logic [NUM_SRC-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [NUM_SRC-1:0]        cdb_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_SRC (NUM_SRC),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // Advance past the next active edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                 = v;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d, input logic [NUM_SRC-1:0] s);
    logic [1+TAG_W+DATA_W+NUM_SRC-1:0] obs;
    logic [1+TAG_W+DATA_W+NUM_SRC-1:0] exp;
    obs = {cdb_valid, cdb_tag, cdb_data, cdb_src};
    exp = {v, t, d, s};
    checks++;
    assert (obs === exp)
      $display("t=%0t %s: cdb v=%0b tag=%0h data=%0h src=%b", $time, name,
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    else begin
      errors++;
      $error("FAIL %s: observed v=%0b tag=%0h data=%0h src=%b expected v=%0b tag=%0h data=%0h src=%b",
             name, cdb_valid, cdb_tag, cdb_data, cdb_src, v, t, d, s);
    end
  endtask

  task automatic chk_rdy(input string name, input logic [NUM_SRC-1:0] exp);
    checks++;
    assert (req_ready === exp)
      $display("t=%0t %s: req_ready=%b", $time, name, req_ready);
    else begin
      errors++;
      $error("FAIL %s: observed req_ready=%b expected %b", name, req_ready, exp);
    end
  endtask

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- 1. Reset with all requesters valid ----
    rst       = 1'b1;
    rdy       = 1'b1;
    clear     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    set_src(0, 1'b1, 4'h1, 32'h0000_0011);
    set_src(1, 1'b1, 4'h2, 32'h0000_0022);
    set_src(2, 1'b1, 4'h3, 32'h0000_0033);
    tick();
    tick();
    chk_cdb("reset_cdb", 1'b0, 4'h0, 32'h0, 3'b000);
    chk_rdy("reset_ready", 3'b000);
    rst       = 1'b0;
    req_valid = '0;
    settle();
    chk_rdy("post_reset_ready", 3'b111);
    tick();
    chk_cdb("post_reset_no_bcast", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 2. Single source, two-edge latency, one-cycle pulse ----
    set_src(0, 1'b1, 4'h5, 32'h0000_1234);
    tick();                                  // edge E: accepted
    set_src(0, 1'b0, 4'h0, 32'h0);
    settle();
    chk_cdb("single_no_bypass", 1'b0, 4'h0, 32'h0, 3'b000);
    tick();                                  // edge E+1: broadcast
    chk_cdb("single_bcast", 1'b1, 4'h5, 32'h0000_1234, 3'b001);
    tick();
    chk_cdb("single_pulse_end", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 6. Flush drops a pending LSB entry ----
    set_src(1, 1'b1, 4'h4, 32'h0000_4444);
    tick();                                  // LSB buffered
    set_src(1, 1'b0, 4'h0, 32'h0);
    clear = 1'b1;
    settle();
    chk_rdy("flush_ready", 3'b000);
    tick();
    clear = 1'b0;
    chk_cdb("flush_cdb", 1'b0, 4'h0, 32'h0, 3'b000);
    tick();
    chk_cdb("flush_tag4_gone", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 3. Contention: all three present at once, tags 1/2/3 ----
    // After the flush the round-robin pointer is back at 0, so both
    // arbitration modes give ALU, LSB, Branch order here.
    set_src(0, 1'b1, 4'h1, 32'h0000_0011);
    set_src(1, 1'b1, 4'h2, 32'h0000_0022);
    set_src(2, 1'b1, 4'h3, 32'h0000_0033);
    settle();
    chk_rdy("cont_ready_empty", 3'b111);
    tick();                                  // all accepted
    req_valid = '0;
    settle();
    chk_cdb("cont_latency", 1'b0, 4'h0, 32'h0, 3'b000);
    chk_rdy("cont_ready_wait1", 3'b001);
    tick();
    chk_cdb("cont_bcast1", 1'b1, 4'h1, 32'h0000_0011, 3'b001);
    chk_rdy("cont_ready_wait2", 3'b011);
    tick();
    chk_cdb("cont_bcast2", 1'b1, 4'h2, 32'h0000_0022, 3'b010);
    chk_rdy("cont_ready_wait3", 3'b111);
    tick();
    chk_cdb("cont_bcast3", 1'b1, 4'h3, 32'h0000_0033, 3'b100);
    tick();
    chk_cdb("cont_idle", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 4. ALU streams while LSB holds tag 7 ----
    set_src(0, 1'b1, 4'hA, 32'h0000_A0A0);
    set_src(1, 1'b1, 4'h7, 32'h0000_7777);
    tick();                                  // E0: both buffered
    set_src(1, 1'b0, 4'h0, 32'h0);
    set_src(0, 1'b1, 4'hB, 32'h0000_B0B0);
    settle();
    chk_rdy("stream_ready0", 3'b101);
    tick();                                  // E1: A out, B refills ALU
    chk_cdb("stream_bcastA", 1'b1, 4'hA, 32'h0000_A0A0, 3'b001);
    set_src(0, 1'b0, 4'h0, 32'h0);
    settle();
`ifdef CDB_ARB_RR_EN
    chk_rdy("stream_ready1", 3'b110);
    tick();
    chk_cdb("stream_bcast7", 1'b1, 4'h7, 32'h0000_7777, 3'b010);
    tick();
    chk_cdb("stream_bcastB", 1'b1, 4'hB, 32'h0000_B0B0, 3'b001);
`else
    chk_rdy("stream_ready1", 3'b101);
    tick();
    chk_cdb("stream_bcastB", 1'b1, 4'hB, 32'h0000_B0B0, 3'b001);
    tick();
    chk_cdb("stream_bcast7", 1'b1, 4'h7, 32'h0000_7777, 3'b010);
`endif
    tick();
    chk_cdb("stream_idle", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 5. Branch granted and refilled on the same edge ----
    set_src(2, 1'b1, 4'h9, 32'h0000_9999);
    tick();                                  // tag 9 buffered
    set_src(2, 1'b1, 4'hA, 32'h0000_1010);   // tag 10 waiting
    settle();
    chk_rdy("refill_ready", 3'b111);
    tick();
    chk_cdb("refill_bcast9", 1'b1, 4'h9, 32'h0000_9999, 3'b100);
    set_src(2, 1'b0, 4'h0, 32'h0);
    tick();
    chk_cdb("refill_bcast10", 1'b1, 4'hA, 32'h0000_1010, 3'b100);
    tick();
    chk_cdb("refill_idle", 1'b0, 4'h0, 32'h0, 3'b000);

    // ---- 7. Stall with a pending entry ----
    set_src(0, 1'b1, 4'hE, 32'h0000_EEEE);
    set_src(1, 1'b1, 4'hF, 32'h0000_FFFF);
    tick();                                  // both buffered
    req_valid = '0;
    tick();
    chk_cdb("stall_pre", 1'b1, 4'hE, 32'h0000_EEEE, 3'b001);
    rdy = 1'b0;
    settle();
    chk_rdy("stall_ready", 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cdb($sformatf("stall_hold%0d", k), 1'b1, 4'hE, 32'h0000_EEEE, 3'b001);
    end
    rdy = 1'b1;
    settle();
    chk_rdy("stall_resume_ready", 3'b111);
    tick();
    chk_cdb("stall_resume_bcast", 1'b1, 4'hF, 32'h0000_FFFF, 3'b010);
    tick();
    chk_cdb("stall_idle", 1'b0, 4'h0, 32'h0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
